// File: rtl/btn_step_reader.sv
// Purpose: two raw pushbuttons -> 2-flop sync -> debounce -> press edge -> 3-bit up/down step count.
// Latency: raw edge to btn_lvl is DEBOUNCE_CYCLES+1 edges, to count/step one edge later; all outputs registered.
// Build option: define BTN_SATURATE_EN to clamp count at 0 and 7 instead of wrapping modulo 8.
module btn_step_reader #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       sysCLK,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       en,
  output logic [2:0] count,
  output logic       step,
  output logic       dir,
  output logic [1:0] btn_lvl
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the up button, index 1 the down button throughout.
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] lvl;
  logic [1:0] lvl_q;
  logic [1:0] press;

  logic       up_ev;
  logic       dn_ev;
  logic       up_room;
  logic       dn_room;
  logic [2:0] count_n;
  logic       dir_n;
  logic       step_n;

  // Two-flop synchroniser for both raw buttons.
  always_ff @(posedge sysCLK or negedge reset) begin
    if (!reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {btnD, btnU};
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic             lvl_r;
    logic [CNT_W-1:0] cnt_r;

    // Level flips only after the synchronised input has disagreed with it for DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge sysCLK or negedge reset) begin
      if (!reset) begin
        lvl_r <= 1'b0;
        cnt_r <= '0;
      end else if (s2[i] == lvl_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        lvl_r <= s2[i];
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end

    assign lvl[i] = lvl_r;
  end

  // A press is a 0->1 transition of the debounced level; releases are ignored.
  assign press = lvl & ~lvl_q;
  assign up_ev = press[0] & ~press[1];
  assign dn_ev = press[1] & ~press[0];

  // Decide the next count/dir/step; simultaneous presses cancel, en=0 drops the event outright.
  always_comb begin
    count_n = count;
    dir_n   = dir;
    step_n  = 1'b0;
`ifdef BTN_SATURATE_EN
    up_room = (count != 3'd7);
    dn_room = (count != 3'd0);
`else
    up_room = 1'b1;
    dn_room = 1'b1;
`endif
    if (en) begin
      if (up_ev && up_room) begin
        count_n = count + 3'd1;
        dir_n   = 1'b1;
        step_n  = 1'b1;
      end else if (dn_ev && dn_room) begin
        count_n = count - 3'd1;
        dir_n   = 1'b0;
        step_n  = 1'b1;
      end
    end
  end

  // Registered outputs plus the delayed level copy used for edge detection.
  always_ff @(posedge sysCLK or negedge reset) begin
    if (!reset) begin
      lvl_q <= 2'b00;
      count <= 3'd0;
      dir   <= 1'b0;
      step  <= 1'b0;
    end else begin
      lvl_q <= lvl;
      count <= count_n;
      dir   <= dir_n;
      step  <= step_n;
    end
  end

  assign btn_lvl = lvl;

endmodule

// File: tb/tb_btn_step_reader.sv
// Bench for btn_step_reader: directed scenarios plus random button traffic against a window-based model.
// Expected step events are queued by the model and popped by a monitor whenever the DUT pulses step.
// Define BTN_SATURATE_EN for both bench and RTL to check the saturating build.
module tb_btn_step_reader;

  localparam int DC   = 4;
  localparam int HOLD = 2 * DC + 4;
`ifdef BTN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       sysCLK = 1'b0;
  logic       reset  = 1'b0;
  logic       btnU   = 1'b0;
  logic       btnD   = 1'b0;
  logic       en     = 1'b1;
  logic [2:0] count;
  logic       step;
  logic       dir;
  logic [1:0] btn_lvl;

  btn_step_reader #(.DEBOUNCE_CYCLES(DC)) dut (
    .sysCLK  (sysCLK),
    .reset   (reset),
    .btnU    (btnU),
    .btnD    (btnD),
    .en      (en),
    .count   (count),
    .step    (step),
    .dir     (dir),
    .btn_lvl (btn_lvl)
  );

  always #5 sysCLK = ~sysCLK;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounced level flips once the last DC synchronised samples all disagree with it;
  // the synchronised sample seen at edge m is the raw value captured two edges earlier.
  typedef struct {
    int cnt;
    bit dir;
    int cyc;
  } ev_t;

  ev_t sb[$];
  bit  hist[2][$];
  bit  win[2][$];
  bit  m_lvl[2];
  bit  rose[2];
  int  m_cnt;
  bit  m_dir;
  bit  m_step;
  int  cyc = 0;

  task automatic m_reset();
    for (int b = 0; b < 2; b++) begin
      hist[b].delete();
      hist[b].push_back(1'b0);
      hist[b].push_back(1'b0);
      win[b].delete();
      m_lvl[b] = 1'b0;
      rose[b]  = 1'b0;
    end
    m_cnt  = 0;
    m_dir  = 1'b0;
    m_step = 1'b0;
    sb.delete();
  endtask

  initial m_reset();

  always @(posedge sysCLK or negedge reset) begin
    if (!reset) begin
      m_reset();
    end else begin
      bit [1:0] raw;
      bit       all_diff;
      cyc++;
      m_step = 1'b0;
      if (en && (rose[0] != rose[1])) begin
        if (rose[0]) begin
          if (!SAT || m_cnt < 7) begin
            m_cnt  = (m_cnt + 1) % 8;
            m_dir  = 1'b1;
            m_step = 1'b1;
          end
        end else begin
          if (!SAT || m_cnt > 0) begin
            m_cnt  = (m_cnt + 7) % 8;
            m_dir  = 1'b0;
            m_step = 1'b1;
          end
        end
      end
      if (m_step) sb.push_back('{m_cnt, m_dir, cyc});
      raw = {btnD, btnU};
      for (int b = 0; b < 2; b++) begin
        hist[b].push_back(raw[b]);
        while (hist[b].size() > 3) void'(hist[b].pop_front());
        win[b].push_back(hist[b][0]);
        while (win[b].size() > DC) void'(win[b].pop_front());
        rose[b]  = 1'b0;
        all_diff = (win[b].size() == DC);
        foreach (win[b][j]) if (win[b][j] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[b] = ~m_lvl[b];
          rose[b]  = m_lvl[b];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge sysCLK) begin
    if (checking) begin
      chk("step", 32'(step), 32'(m_step));
      chk("btn_lvl", 32'(btn_lvl), 32'({m_lvl[1], m_lvl[0]}));
      chk("count", 32'(count), m_cnt);
      if (step === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_step", 32'(1), 32'(0));
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("sb_count", 32'(count), e.cnt);
          chk("sb_dir", 32'(dir), 32'(e.dir));
          chk("sb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit u, input bit d, input bit e, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sysCLK);
      btnU = u;
      btnD = d;
      en   = e;
    end
  endtask

  task automatic press(input bit u, input bit d, input bit e);
    drive(u, d, e, HOLD);
    drive(1'b0, 1'b0, e, HOLD);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(0));
    chk({tag, "_step"}, 32'(step), 32'(0));
    chk({tag, "_dir"}, 32'(dir), 32'(0));
    chk({tag, "_btn_lvl"}, 32'(btn_lvl), 32'(0));
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    checking = 1'b1;
    @(negedge sysCLK);
    reset = 1'b1;

    // Clean press, held well past the debounce window.
    drive(1'b0, 1'b0, 1'b1, 5);
    press(1'b1, 1'b0, 1'b1);
    chk("clean_count", 32'(count), 32'(1));
    chk("clean_dir", 32'(dir), 32'(1));

    // Bounce with 2-cycle toggles, then a steady hold.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 1'b1, 2);
    end
    press(1'b1, 1'b0, 1'b1);
    chk("bounce_count", 32'(count), 32'(2));

    // Eight ups pass through the wrap point (or stick at 7), then one down.
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 1'b1);
    chk("wrap_count", 32'(count), SAT ? 32'(7) : 32'(2));
    press(1'b0, 1'b1, 1'b1);
    chk("wrap_down_count", 32'(count), SAT ? 32'(6) : 32'(1));
    chk("wrap_down_dir", 32'(dir), 32'(0));

    // Simultaneous presses cancel; a lone down afterwards still counts.
    press(1'b1, 1'b1, 1'b1);
    chk("simul_count", 32'(count), SAT ? 32'(6) : 32'(1));
    press(1'b0, 1'b1, 1'b1);
    chk("simul_down_count", 32'(count), SAT ? 32'(5) : 32'(0));

    // Press with en low, raise en while still held: event is gone for good.
    drive(1'b1, 1'b0, 1'b0, DC + 4);
    drive(1'b1, 1'b0, 1'b1, HOLD);
    drive(1'b0, 1'b0, 1'b1, HOLD);
    chk("en_gate_count", 32'(count), SAT ? 32'(5) : 32'(0));
    press(1'b1, 1'b0, 1'b1);
    chk("en_after_count", 32'(count), SAT ? 32'(6) : 32'(1));

    // Bring count to 5, then reset mid-debounce with up held through release.
    for (int i = 0; i < 8 && m_cnt != 5; i++) press(m_cnt < 5, m_cnt > 5, 1'b1);
    chk("pre_reset_count", 32'(count), 32'(5));
    drive(1'b1, 1'b0, 1'b1, 3);
    @(posedge sysCLK);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge sysCLK);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, HOLD);
    drive(1'b0, 1'b0, 1'b1, HOLD);
    chk("held_reset_count", 32'(count), 32'(1));
    chk("held_reset_dir", 32'(dir), 32'(1));

    // Random traffic with occasional en drops and one asynchronous reset.
    for (int k = 0; k < 160; k++) begin
      drive(1'($urandom % 2), 1'($urandom % 3 == 0), 1'($urandom % 8 != 0), $urandom_range(1, 14));
      if (k == 80) begin
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("rand_rst");
        @(negedge sysCLK);
        reset = 1'b1;
      end
    end

    drive(1'b0, 1'b0, 1'b1, 3 * HOLD);
    chk("sb_drained", sb.size(), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/btn_step_reader.md
# btn_step_reader

- Input-side counterpart to the seven-segment display path.
- Samples two raw pushbuttons (up, down), synchronises and debounces each one, and turns each debounced press into a single step of a 3-bit wrap-around count.
- The count feeds the existing 3-bit decode/seven-segment chain in place of the free-running counter.
- Also produces a one-cycle step strobe and a direction flag for downstream logic.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronised input must differ from its debounced level before that level flips (10 ms at 100 MHz); legal range ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter; derived, never overridden.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- sysCLK  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- btnU  input  1  raw up button, asynchronous to sysCLK, active-high.
- btnD  input  1  raw down button, asynchronous to sysCLK, active-high.
- en  input  1  1 = press events act on count; 0 = press events discarded, not queued.
- count  output  3  current step value.
- step  output  1  one-cycle strobe on the cycle count changes.
- dir  output  1  direction of last change: 1 = up, 0 = down.
- btn_lvl  output  2  debounced levels {D, U}.

## Operation

- Synchroniser: each button passes through a 2-flop chain (s1→s2). Both flops reset to 0.
- Debouncer, per button, with debounced level L (reset 0) and counter C (reset 0):
  - If s2 == L: C ← 0.
  - Else, if C == DEBOUNCE_CYCLES−1: L ← s2 and C ← 0.
  - Else: C ← C+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves L unchanged.
- Press event: L goes 0→1, detected against a registered copy of L (reset 0). Release (1→0) produces no event.
- Update on the edge after a press event, when en = 1:
  - Up event only: count ← count+1 mod 8, dir ← 1, step ← 1.
  - Down event only: count ← count−1 mod 8, dir ← 0, step ← 1.
  - Up and down events in the same cycle: no change, step ← 0, dir held.
  - en = 0: event dropped, no change, step ← 0.
- step is 0 on every other cycle.
- Wrap-around: 7 + up → 0, 0 + down → 7.
- A held button produces exactly one event, with no auto-repeat.
- Reset values: count = 0, step = 0, dir = 0, btn_lvl = 0, with all internal counters and flops at 0.
- Reset mid-debounce discards partial counts.
- A button held through reset release is seen as a new press: one event after the full debounce latency.

## Timing

- Press latency: raw rising edge stable before sysCLK edge k → L rises at edge k+1+DEBOUNCE_CYCLES → count/step update at edge k+2+DEBOUNCE_CYCLES. This is exact, with ±1 edge allowed only for raw input metastability.
- btn_lvl is L directly, so it leads step by one cycle.
- Release latency to btn_lvl matches press latency.
- Minimum spacing between two counted presses of the same button is 2·DEBOUNCE_CYCLES cycles (press plus release debounce).
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration

- BTN_SATURATE_EN defined:
  - count saturates: up at 7 and down at 0 produce no change and no step pulse, and dir is held.
  - All other behaviour is unchanged.
- Not defined (default): modulo-8 wrap as described in Operation.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and en = 1 unless stated.

- Clean press: hold btnU from edge 10 → btn_lvl[0] = 1 at edge 15; count 0→1 with step = 1 for one cycle at edge 16 and dir = 1; no further steps while held.
- Bounce: toggle btnU every 2 cycles for 20 cycles, then hold high → no step during the bouncing; exactly one step, count = 1, four debounce cycles after the last toggle.
- Wrap: 8 clean btnU presses from count = 0 → count 1…7, then 0, with 8 step pulses; then one btnD press → count = 7, dir = 0. With BTN_SATURATE_EN: 8 presses give count = 7 and only 7 steps; btnD from 0 gives no step.
- Simultaneous: btnU and btnD rise on the same edge → no step and count unchanged. Releasing both, then pressing btnD alone → count−1.
- en gating: press btnU with en = 0, raise en while the button is still held → no step ever; the next press with en = 1 steps normally.
- Async reset: assert reset low mid-debounce at count = 5 → all outputs 0 immediately without a clock edge. Release reset with btnU still high → one step to count = 1 at 2+DEBOUNCE_CYCLES edges after release.
